// File: rtl/tr_ramp_step_gen.sv
// rtl/tr_ramp_step_gen.sv - tracking stepper controller: deviation -> target rate, slew limiter, NCO step pulses
// Ports:
//   clk, rst (async, active-low)          clock and reset
//   data_valid, x                         1-cycle strobe and ADC sample
//   tr_mode_enable                        1 = track, 0 = ramp down to stop
//   x0, dx1, dx2                          centre, dead-band edge, saturation edge
//   f_min, f_max, k, accel                rate at dx1, max rate, slope, max change per update
//   drv_step, drv_dir, drv_enable_SM      motor driver step pulse, direction, enable
//   rate                                  current slewed rate word
//   step_overrun                          sticky: NCO carry lost while a pulse was high
module tr_ramp_step_gen #(
  parameter int X_W       = 36,
  parameter int RATE_W    = 17,
  parameter int K_W       = 16,
  parameter int ACC_W     = 26,
  parameter int PULSE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic              tr_mode_enable,
  input  logic [X_W-1:0]    x,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    dx1,
  input  logic [X_W-1:0]    dx2,
  input  logic [RATE_W-1:0] f_min,
  input  logic [RATE_W-1:0] f_max,
  input  logic [K_W-1:0]    k,
  input  logic [RATE_W-1:0] accel,
  output logic              drv_step,
  output logic              drv_dir,
  output logic              drv_enable_SM,
  output logic [RATE_W-1:0] rate,
  output logic              step_overrun
);
  localparam int PROD_W = X_W + K_W + 1;
  localparam int SUM_W  = ACC_W + 1;
  localparam int CNT_W  = $clog2(PULSE_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, BRAKE, REVERSE} state_t;
  state_t state_q, state_d;

  logic              valid1_q, valid1_d;
  logic [X_W-1:0]    abs_e_q, abs_e_d;
  logic              tgt_dir1_q, tgt_dir1_d;
  logic              valid2_q, valid2_d;
  logic [RATE_W-1:0] target_q, target_d;
  logic              tgt_dir2_q, tgt_dir2_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              dir_q, dir_d;
  logic              en_q, en_d;
  logic              stopping_q, stopping_d;
  logic              overrun_q, overrun_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;

  logic [X_W-1:0]    excess;
  logic [PROD_W-1:0] lin_full;
  logic [SUM_W-1:0]  nco_sum;

  // Linear band evaluated wide enough that a large k can never wrap below f_max.
  assign excess   = abs_e_q - dx1;
  assign lin_full = PROD_W'(f_min) + PROD_W'(excess) * PROD_W'(k);
  assign nco_sum  = {1'b0, acc_q} + SUM_W'(rate_q);

  function automatic logic [RATE_W-1:0] ramp(input logic [RATE_W-1:0] cur,
                                             input logic [RATE_W-1:0] goal,
                                             input logic [RATE_W-1:0] step);
    logic [RATE_W-1:0] diff;
    if (goal >= cur) begin
      diff = goal - cur;
      ramp = cur + ((diff < step) ? diff : step);
    end else begin
      diff = cur - goal;
      ramp = cur - ((diff < step) ? diff : step);
    end
  endfunction

  always_comb begin
    valid1_d    = data_valid;
    abs_e_d     = abs_e_q;
    tgt_dir1_d  = tgt_dir1_q;
    valid2_d    = valid1_q;
    target_d    = target_q;
    tgt_dir2_d  = tgt_dir2_q;
    state_d     = state_q;
    rate_d      = rate_q;
    dir_d       = dir_q;
    en_d        = en_q;
    stopping_d  = stopping_q;
    overrun_d   = overrun_q;
    acc_d       = acc_q;
    pulse_cnt_d = (pulse_cnt_q != '0) ? pulse_cnt_q - CNT_W'(1) : '0;

    // S1: magnitude and sign of deviation; e == 0 keeps the current direction.
    if (data_valid) begin
      abs_e_d    = (x >= x0) ? x - x0 : x0 - x;
      tgt_dir1_d = (x > x0) ? 1'b1 : ((x < x0) ? 1'b0 : dir_q);
    end

    // S2: target rate.  |e| > dx1 >= dx2 falls into the f_max branch naturally.
    if (valid1_q) begin
      tgt_dir2_d = tgt_dir1_q;
      if (!tr_mode_enable || abs_e_q <= dx1)
        target_d = '0;
      else if (abs_e_q >= dx2 || lin_full >= PROD_W'(f_max))
        target_d = f_max;
      else
        target_d = lin_full[RATE_W-1:0];
    end

    // NCO: a carry launches a pulse next cycle unless one is still high.
    if (state_q == RUN || state_q == BRAKE) begin
      acc_d = nco_sum[ACC_W-1:0];
      if (nco_sum[ACC_W]) begin
        if (pulse_cnt_q != '0) overrun_d = 1'b1;
        else                   pulse_cnt_d = CNT_W'(PULSE_CYC);
      end
    end

    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (valid2_q && target_q != '0) begin
          dir_d      = tgt_dir2_q;
          en_d       = 1'b1;
          rate_d     = ramp(rate_q, target_q, accel);
          stopping_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (valid2_q && tgt_dir2_q != dir_q) begin
          rate_d     = ramp(rate_q, '0, accel);
          stopping_d = 1'b0;
          state_d    = BRAKE;
        end else begin
          if (valid2_q) begin
            rate_d     = ramp(rate_q, target_q, accel);
            stopping_d = (target_q == '0) && (rate_d == '0);
          end
          // rate_q == 0 guarantees no carry can start a pulse this cycle.
          if (stopping_d && rate_q == '0 && pulse_cnt_q == '0) begin
            en_d       = 1'b0;
            stopping_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      BRAKE: begin
        if (valid2_q) begin
          if (rate_q == '0 && pulse_cnt_q == '0) state_d = REVERSE;
          else                                   rate_d  = ramp(rate_q, '0, accel);
        end
      end
      REVERSE: begin
        dir_d   = ~dir_q;
        acc_d   = '0;
        state_d = RUN;
        // An update landing here still counts, against the new direction.
        if (valid2_q && tgt_dir2_q == ~dir_q) rate_d = ramp(rate_q, target_q, accel);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid1_q    <= 1'b0;
      abs_e_q     <= '0;
      tgt_dir1_q  <= 1'b0;
      valid2_q    <= 1'b0;
      target_q    <= '0;
      tgt_dir2_q  <= 1'b0;
      rate_q      <= '0;
      dir_q       <= 1'b0;
      en_q        <= 1'b0;
      stopping_q  <= 1'b0;
      overrun_q   <= 1'b0;
      acc_q       <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid1_q    <= valid1_d;
      abs_e_q     <= abs_e_d;
      tgt_dir1_q  <= tgt_dir1_d;
      valid2_q    <= valid2_d;
      target_q    <= target_d;
      tgt_dir2_q  <= tgt_dir2_d;
      rate_q      <= rate_d;
      dir_q       <= dir_d;
      en_q        <= en_d;
      stopping_q  <= stopping_d;
      overrun_q   <= overrun_d;
      acc_q       <= acc_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign drv_step      = (pulse_cnt_q != '0);
  assign drv_dir       = dir_q;
  assign drv_enable_SM = en_q;
  assign rate          = rate_q;
  assign step_overrun  = overrun_q;

endmodule

// File: tb/tb_tr_ramp_step_gen.sv
// tb/tb_tr_ramp_step_gen.sv - scoreboard bench for tr_ramp_step_gen
module tb_tr_ramp_step_gen;
  localparam int X_W = 36, RATE_W = 19, K_W = 16, ACC_W = 20, PULSE_CYC = 4;

  logic              clk = 1'b0, rst = 1'b0, data_valid = 1'b0, tr_mode_enable = 1'b1;
  logic [X_W-1:0]    x = '0, x0 = 36'd5, dx1 = 36'd250, dx2 = 36'd555;
  logic [RATE_W-1:0] f_min = 19'd6000, f_max = 19'd50000, accel = 19'd1000;
  logic [K_W-1:0]    k = 16'd144;
  logic              drv_step, drv_dir, drv_enable_SM, step_overrun;
  logic [RATE_W-1:0] rate;

  tr_ramp_step_gen #(.X_W(X_W), .RATE_W(RATE_W), .K_W(K_W), .ACC_W(ACC_W), .PULSE_CYC(PULSE_CYC)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .tr_mode_enable(tr_mode_enable),
    .x(x), .x0(x0), .dx1(dx1), .dx2(dx2), .f_min(f_min), .f_max(f_max), .k(k), .accel(accel),
    .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable_SM(drv_enable_SM), .rate(rate),
    .step_overrun(step_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RATE_W-1:0] rate;
    logic              en;
    logic              dir;
    bit                chk_en;
    bit                chk_dir;
    int                tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, tag_n = 0, step_cnt = 0;
  logic [2:0] dvp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs of a strobe appear right after the third rising edge.
  always @(posedge clk or negedge rst)
    if (!rst) dvp <= '0;
    else      dvp <= {dvp[1:0], data_valid};

  initial begin : monitor
    exp_t e;
    logic p_step = 1'b0, p_dir = 1'b0, p_en = 1'b0, p_rst = 1'b0;
    logic [RATE_W-1:0] p_rate = '0;
    forever begin
      @(negedge clk);
      if (dvp[2]) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got update with rate %0d, expected none", rate);
        end else begin
          e = sb.pop_front();
          check($sformatf("rate#%0d", e.tag), rate, e.rate);
          if (e.chk_en)  check($sformatf("en#%0d", e.tag), drv_enable_SM, e.en);
          if (e.chk_dir) check($sformatf("dir#%0d", e.tag), drv_dir, e.dir);
        end
      end
      if (rst && p_rst) begin
        if (drv_dir !== p_dir) begin
          check("dir_change_prev_step", p_step, 0);
          check("dir_change_prev_rate", p_rate, 0);
        end
        if (p_en && !drv_enable_SM) begin
          check("en_fall_step", drv_step, 0);
          check("en_fall_prev_rate", p_rate, 0);
        end
        if (drv_step && !p_step) step_cnt++;
      end
      p_step = drv_step; p_dir = drv_dir; p_en = drv_enable_SM; p_rate = rate; p_rst = rst;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [X_W-1:0] xv, input int er, input logic een, input logic edir,
                     input bit cen, input bit cdir, input int gap);
    exp_t e;
    x = xv;
    data_valid = 1'b1;
    e.rate = RATE_W'(er); e.en = een; e.dir = edir; e.chk_en = cen; e.chk_dir = cdir; e.tag = tag_n++;
    sb.push_back(e);
    @(posedge clk); #1;
    data_valid = 1'b0;
    for (int i = 1; i < gap; i++) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int s0, last, iv, n, got;
    logic ps;
    idle(3);
    check("rst_rate", rate, 0);
    check("rst_en", drv_enable_SM, 0);
    check("rst_dir", drv_dir, 0);
    check("rst_step", drv_step, 0);
    check("rst_ovr", step_overrun, 0);
    rst = 1'b1;
    idle(2);

    // 1: dead band, |e| = 100
    s0 = step_cnt;
    for (int i = 0; i < 2000; i++) upd(36'd105, 0, 1'b0, 1'b0, 1, 1, 5);
    idle(4);
    check("t1_steps", step_cnt - s0, 0);

    // 2: linear band, target 6000 + 144*150 = 27600
    for (int i = 1; i <= 28; i++) upd(36'd405, (i < 28) ? i * 1000 : 27600, 1'b1, 1'b1, 1, 1, 5);
    for (int i = 0; i < 3; i++) upd(36'd405, 27600, 1'b1, 1'b1, 1, 1, 5);
    idle(4);
    last = -1; n = 0; ps = drv_step;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (drv_step && !ps) begin
        if (last >= 0) begin
          iv = c - last;
          check($sformatf("t2_spacing_%0d_is_37_or_38", iv), (iv == 37 || iv == 38), 1);
          n++;
        end
        last = c;
      end
      ps = drv_step;
    end
    check("t2_enough_steps", n >= 14, 1);
    check("t2_ovr", step_overrun, 0);
    idle(1);

    // 3: k = 65535 would wrap a narrow product to 5696; must saturate at 50000
    k = 16'd65535;
    for (int i = 1; i <= 23; i++) upd(36'd559, (i < 23) ? 27600 + i * 1000 : 50000, 1'b1, 1'b1, 1, 1, 1);
    for (int i = 0; i < 3; i++) upd(36'd30005, 50000, 1'b1, 1'b1, 1, 1, 1);
    idle(4);
    k = 16'd144;

    // 4: pull rate down to 20000, then reverse direction (e = -600)
    f_max = 19'd20000;
    for (int i = 1; i <= 30; i++) upd(36'd30005, 50000 - i * 1000, 1'b1, 1'b1, 1, 1, 5);
    idle(4);
    f_max = 19'd50000;
    x0 = 36'd1000;
    for (int i = 1; i <= 20; i++) upd(36'd400, 20000 - i * 1000, 1'b1, 1'b1, 1, 1, 5);
    upd(36'd400, 0, 1'b1, 1'b0, 1, 0, 5);
    for (int i = 22; i <= 71; i++) upd(36'd400, (i - 21) * 1000, 1'b1, 1'b0, 1, 1, 5);
    idle(4);
    check("t4_dir_after", drv_dir, 0);

    // 5: settle at 27600 (e = -400), then disable tracking
    for (int i = 1; i <= 23; i++) upd(36'd600, (i < 23) ? 50000 - i * 1000 : 27600, 1'b1, 1'b0, 1, 1, 5);
    idle(4);
    tr_mode_enable = 1'b0;
    for (int i = 1; i <= 27; i++) upd(36'd600, 27600 - i * 1000, 1'b1, 1'b0, 1, 1, 5);
    upd(36'd600, 0, 1'b0, 1'b0, 0, 1, 5);
    upd(36'd600, 0, 1'b0, 1'b0, 1, 1, 5);
    idle(4);
    check("t5_ovr", step_overrun, 0);
    tr_mode_enable = 1'b1;
    for (int i = 1; i <= 10; i++) upd(36'd1400, i * 1000, 1'b1, 1'b1, 1, 1, 5);
    idle(4);
    got = 0;
    for (int c = 0; c < 300 && got == 0; c++) begin
      @(negedge clk);
      if (drv_step) got = 1;
    end
    check("t5_pulse_seen", got, 1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_step", drv_step, 0);
    check("t5_rst_dir", drv_dir, 0);
    check("t5_rst_en", drv_enable_SM, 0);
    check("t5_rst_rate", rate, 0);
    check("t5_rst_ovr", step_overrun, 0);
    idle(3);
    rst = 1'b1;
    idle(2);

    // 6: rate 2^18 gives a carry every 4 clk against a 4-clk pulse
    f_max = 19'd262144;
    accel = 19'd131072;
    upd(36'd1600, 131072, 1'b1, 1'b1, 1, 1, 5);
    upd(36'd1600, 262144, 1'b1, 1'b1, 1, 1, 5);
    idle(50);
    check("t6_ovr_set", step_overrun, 1);
    tr_mode_enable = 1'b0;
    upd(36'd1600, 131072, 1'b1, 1'b1, 1, 1, 5);
    upd(36'd1600, 0, 1'b0, 1'b1, 0, 1, 5);
    upd(36'd1600, 0, 1'b0, 1'b1, 1, 1, 5);
    idle(10);
    check("t6_ovr_sticky", step_overrun, 1);
    rst = 1'b0;
    #1;
    check("t6_ovr_rst", step_overrun, 0);
    idle(2);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
